multiword_serial_adder: RTL and testbench

MULTIWORD_SERIAL_ADDER -- requirements
Module: multiword_serial_adder

---
 rtl/multiword_serial_adder_pkg.sv | 20 ++
 rtl/multiword_serial_adder_slice_adder.sv | 48 ++++
 rtl/multiword_serial_adder.sv | 133 +++++++++++++
 tb/tb_multiword_serial_adder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/multiword_serial_adder_pkg.sv
// ============================================================================
// multiword_serial_adder_pkg : shared FSM encoding and width defaults
// Revision: 1.0
// ============================================================================
`default_nettype none

package multiword_serial_adder_pkg;

   localparam int WORD_BITS_DEF  = 16;
   localparam int SLICE_BITS_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/multiword_serial_adder_slice_adder.sv
// ============================================================================
// slice_adder : SLICE_BITS-wide carry-lookahead adder
// Revision: 1.0
// ============================================================================
`default_nettype none

module slice_adder #(
   parameter int SLICE_BITS = 4
) (
   input  logic [SLICE_BITS-1:0] a_i,
   input  logic [SLICE_BITS-1:0] b_i,
   input  logic                  cin_i,
   output logic [SLICE_BITS-1:0] sum_o,
   output logic                  cout_o,
   output logic                  cmsb_o
);

   logic [SLICE_BITS-1:0] w_g;
   logic [SLICE_BITS-1:0] w_p;
   logic [SLICE_BITS:0]   w_c;

   assign w_g = a_i & b_i;
   assign w_p = a_i ^ b_i;

   // Every carry is a flat sum of generate terms, never a chain through w_c.
   always_comb begin
      logic w_acc;
      logic w_pr;
      w_c    = '0;
      w_c[0] = cin_i;
      for (int i = 0; i < SLICE_BITS; i++) begin
         w_acc = w_g[i];
         w_pr  = w_p[i];
         for (int j = i - 1; j >= 0; j--) begin
            w_acc = w_acc | (w_pr & w_g[j]);
            w_pr  = w_pr & w_p[j];
         end
         w_c[i+1] = w_acc | (w_pr & cin_i);
      end
   end

   assign sum_o  = w_p ^ w_c[SLICE_BITS-1:0];
   assign cout_o = w_c[SLICE_BITS];
   assign cmsb_o = w_c[SLICE_BITS-1];

endmodule

`default_nettype wire

// File: rtl/multiword_serial_adder.sv
// ============================================================================
// multiword_serial_adder : slice-serial add/subtract with carry, overflow, zero
// Revision: 1.0
// ============================================================================
`default_nettype none

module multiword_serial_adder
   import multiword_serial_adder_pkg::*;
#(
   parameter int WORD_BITS  = WORD_BITS_DEF,
   parameter int SLICE_BITS = SLICE_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 sub,
   input  logic [WORD_BITS-1:0] a,
   input  logic [WORD_BITS-1:0] b,
   input  logic                 cin,
   output logic                 busy,
   output logic                 done,
   output logic [WORD_BITS-1:0] sum,
   output logic                 cout,
   output logic                 ovf,
   output logic                 zero
);

   localparam int N     = WORD_BITS / SLICE_BITS;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   state_t                state_q, state_d;
   logic [WORD_BITS-1:0]  a_q, a_d;
   logic [WORD_BITS-1:0]  b_q, b_d;
   logic                  carry_q, carry_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [WORD_BITS-1:0]  sum_q, sum_d;
   logic                  cout_q, cout_d;
   logic                  ovf_q, ovf_d;
   logic                  zero_q, zero_d;

   logic [SLICE_BITS-1:0] w_a_slice;
   logic [SLICE_BITS-1:0] w_b_slice;
   logic [SLICE_BITS-1:0] w_slice_sum;
   logic                  w_slice_cout;
   logic                  w_slice_cmsb;

   assign w_a_slice = a_q[idx_q*SLICE_BITS +: SLICE_BITS];
   assign w_b_slice = b_q[idx_q*SLICE_BITS +: SLICE_BITS];

   slice_adder #(
      .SLICE_BITS (SLICE_BITS)
   ) u_slice_adder (
      .a_i    (w_a_slice),
      .b_i    (w_b_slice),
      .cin_i  (carry_q),
      .sum_o  (w_slice_sum),
      .cout_o (w_slice_cout),
      .cmsb_o (w_slice_cmsb)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               // Subtraction is a + ~b + 1, so only b and the carry differ.
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub ? 1'b1 : cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[idx_q*SLICE_BITS +: SLICE_BITS] = w_slice_sum;
            carry_d = w_slice_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = DONE;
               cout_d  = w_slice_cout;
               ovf_d   = w_slice_cmsb ^ w_slice_cout;
               zero_d  = (sum_d == '0);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_multiword_serial_adder.sv
// ============================================================================
// tb_multiword_serial_adder : vector table, corner sequences and random ops
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multiword_serial_adder;

   localparam int WB  = 16;
   localparam int LAT = 5;

   typedef struct packed {
      logic [WB-1:0] sum;
      logic          cout;
      logic          ovf;
      logic          zero;
   } res_t;

   typedef struct {
      logic [WB-1:0] a;
      logic [WB-1:0] b;
      logic          sub;
      logic          cin;
      res_t          exp;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          sub;
   logic [WB-1:0] a;
   logic [WB-1:0] b;
   logic          cin;
   logic          busy;
   logic          done;
   logic [WB-1:0] sum;
   logic          cout;
   logic          ovf;
   logic          zero;

   int n_vec  = 0;
   int n_fail = 0;

   multiword_serial_adder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf),
      .zero  (zero)
   );

   always #5 clk = ~clk;

   // Reference: whole-word arithmetic on the two's-complement operands.
   function automatic res_t model(input logic [WB-1:0] ma, input logic [WB-1:0] mb,
                                  input logic msub, input logic mcin);
      res_t        r;
      logic [WB:0] full;
      if (msub) full = {1'b0, ma} - {1'b0, mb} + (WB+1)'(1 << WB);
      else      full = {1'b0, ma} + {1'b0, mb} + (WB+1)'(mcin);
      r.sum  = full[WB-1:0];
      r.cout = full[WB];
      if (msub) r.ovf = (ma[WB-1] != mb[WB-1]) && (r.sum[WB-1] != ma[WB-1]);
      else      r.ovf = (ma[WB-1] == mb[WB-1]) && (r.sum[WB-1] != ma[WB-1]);
      r.zero = (r.sum == '0);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_res(input string name, input res_t exp);
      chk({name, ".sum"},  32'(sum),  32'(exp.sum));
      chk({name, ".cout"}, 32'(cout), 32'(exp.cout));
      chk({name, ".ovf"},  32'(ovf),  32'(exp.ovf));
      chk({name, ".zero"}, 32'(zero), 32'(exp.zero));
   endtask

   // Called at a negedge; returns at the negedge where done is seen.
   task automatic do_op(input string name, input logic [WB-1:0] ta, input logic [WB-1:0] tb_,
                        input logic tsub, input logic tcin);
      int lat;
      a = ta; b = tb_; sub = tsub; cin = tcin; start = 1'b1;
      lat = 0;
      for (int k = 1; k <= 3 * LAT; k++) begin
         @(negedge clk);
         start = 1'b0;
         a = $urandom; b = $urandom;
         if (done) begin
            lat = k;
            break;
         end
         chk({name, ".busy"}, 32'(busy), 32'(1));
      end
      if (lat == 0) begin
         n_vec++; n_fail++;
         $display("FAIL %s.timeout: no done within %0d cycles", name, 3 * LAT);
      end else begin
         chk({name, ".latency"}, 32'(lat), 32'(LAT));
         chk_res(name, model(ta, tb_, tsub, tcin));
      end
   endtask

   vec_t            vecs[7];
   logic [WB-1:0]   ha[10];
   logic [WB-1:0]   hb[10];
   logic            hs[10];
   res_t            held;
   int              seen_done;

   initial begin
      vecs[0] = '{16'h1234, 16'h1111, 1'b0, 1'b0, '{16'h2345, 1'b0, 1'b0, 1'b0}};
      vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0}};
      vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1}};
      vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, '{16'hFFFE, 1'b0, 1'b0, 1'b0}};
      vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, '{16'h7FFF, 1'b1, 1'b1, 1'b0}};
      vecs[5] = '{16'h00FF, 16'h0000, 1'b0, 1'b1, '{16'h0100, 1'b0, 1'b0, 1'b0}};
      vecs[6] = '{16'h0003, 16'h0003, 1'b1, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1}};

      rst_n = 1'b0; start = 1'b1; sub = 1'b0; a = 16'h1111; b = 16'h2222; cin = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset.busy", 32'(busy), 32'(0));
      chk("reset.done", 32'(done), 32'(0));
      chk_res("reset", '{16'h0000, 1'b0, 1'b0, 1'b0});
      rst_n = 1'b1; start = 1'b0;
      @(negedge clk);

      // Directed table; each entry checked against its hand-written expectation.
      for (int i = 0; i < 7; i++) begin
         do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
         chk_res($sformatf("vec%0d.table", i), vecs[i].exp);
         @(negedge clk);
      end

      // Results hold after DONE returns to IDLE.
      do_op("hold", 16'hABCD, 16'h1357, 1'b1, 1'b0);
      held = model(16'hABCD, 16'h1357, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      chk("hold.done", 32'(done), 32'(0));
      chk("hold.busy", 32'(busy), 32'(0));
      chk_res("hold", held);

      // Start held for 10 cycles with changing operands.
      for (int c = 0; c <= 10; c++) begin
         if (c >= 1) begin
            chk($sformatf("held%0d.done", c), 32'(done), 32'(c % LAT == 0));
            chk($sformatf("held%0d.busy", c), 32'(busy), 32'(c % LAT != 0));
            if (c % LAT == 0)
               chk_res($sformatf("held%0d", c), model(ha[c-LAT], hb[c-LAT], hs[c-LAT], 1'b0));
         end
         if (c < 10) begin
            ha[c] = $urandom; hb[c] = $urandom; hs[c] = 1'($urandom);
            a = ha[c]; b = hb[c]; sub = hs[c]; cin = 1'b0; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end

      // Reset in the second RUN cycle aborts without a done pulse.
      a = 16'h4321; b = 16'h1234; sub = 1'b0; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort.busy", 32'(busy), 32'(0));
      chk("abort.done", 32'(done), 32'(0));
      chk_res("abort", '{16'h0000, 1'b0, 1'b0, 1'b0});
      rst_n = 1'b1;
      seen_done = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) seen_done++;
      end
      chk("abort.no_done", 32'(seen_done), 32'(0));
      do_op("post_abort", 16'h0001, 16'h0001, 1'b0, 1'b0);
      chk_res("post_abort.table", '{16'h0002, 1'b0, 1'b0, 1'b0});

      // Randomized operations, about half issued back-to-back from DONE.
      for (int r = 0; r < 40; r++) begin
         if ($urandom_range(1, 0) == 1) @(negedge clk);
         do_op($sformatf("rand%0d", r), 16'($urandom), 16'($urandom),
               1'($urandom), 1'($urandom));
      end
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
